// File: rtl/barrier_wait_ctrl.sv
// Per-core barrier wait controller: sticky pending bits fed by barrier event pulses,
// plus one RUN/DRAIN/SLEEP/ACK FSM per core that gates the core clock while it waits.
module barrier_wait_ctrl #(
    parameter int NB_CORES = 4,
    parameter int NB_BARR  = 2,
    parameter int ID_W     = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NB_BARR*NB_CORES-1:0] barrier_events_i,
    input  logic [NB_CORES-1:0]         core_wait_req_i,
    input  logic [NB_CORES*ID_W-1:0]    core_wait_id_i,
    input  logic [NB_CORES-1:0]         core_busy_i,
    output logic [NB_CORES-1:0]         core_wait_gnt_o,
    output logic [NB_CORES-1:0]         core_wait_err_o,
    output logic [NB_CORES-1:0]         core_clock_en_o,
    output logic [NB_CORES-1:0]         core_wake_o,
    output logic [NB_CORES*NB_BARR-1:0] pending_o
);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_SLEEP, ST_ACK} state_t;

    logic [NB_CORES*NB_BARR-1:0] pend_q;
    logic [NB_CORES*NB_BARR-1:0] pend_d;
    logic [NB_CORES*NB_BARR-1:0] pend_clr;
    logic [NB_CORES*NB_BARR-1:0] evt_by_core;

    // Events arrive barrier-major; pending is kept core-major.
    for (genvar gi = 0; gi < NB_CORES; gi++) begin : g_remap_core
        for (genvar gb = 0; gb < NB_BARR; gb++) begin : g_remap_barr
            assign evt_by_core[gi*NB_BARR+gb] = barrier_events_i[gb*NB_CORES+gi];
        end
    end

    // A new event outranks an ACK clear on the same bit.
    always_comb begin
        pend_d = (pend_q & ~pend_clr) | evt_by_core;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pending_o = pend_q;

    for (genvar gi = 0; gi < NB_CORES; gi++) begin : g_core
        state_t            state_q, state_d;
        logic [ID_W-1:0]   id_q, id_d;
        logic [ID_W-1:0]   id_sel;
        logic              gnt_q, gnt_d;
        logic              err_q, err_d;
        logic              wake_q, wake_d;
        logic              clk_en_q, clk_en_d;
        logic              id_bad;
        logic              hit;
        logic              req;
        logic [NB_BARR-1:0] clr_vec;

        assign req = core_wait_req_i[gi];

        always_comb begin
            // In RUN the id is still live on the port; afterwards the captured copy rules.
            id_sel = (state_q == ST_RUN) ? core_wait_id_i[gi*ID_W +: ID_W] : id_q;
            id_bad = (32'(id_sel) >= NB_BARR);
            hit    = 1'b0;
            for (int b = 0; b < NB_BARR; b++) begin
                if (32'(id_sel) == b) begin
                    hit = pend_q[gi*NB_BARR+b] | barrier_events_i[b*NB_CORES+gi];
                end
            end

            state_d = state_q;
            id_d    = id_q;
            case (state_q)
                ST_RUN: begin
                    if (req) begin
                        id_d    = core_wait_id_i[gi*ID_W +: ID_W];
                        state_d = (id_bad || hit) ? ST_ACK : ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!req)                  state_d = ST_RUN;
                    else if (hit)              state_d = ST_ACK;
                    else if (!core_busy_i[gi]) state_d = ST_SLEEP;
                end
                ST_SLEEP: begin
                    if (!req)     state_d = ST_RUN;
                    else if (hit) state_d = ST_ACK;
                end
                ST_ACK:  state_d = ST_RUN;
                default: state_d = ST_RUN;
            endcase

            gnt_d    = (state_d == ST_ACK);
            err_d    = (state_d == ST_ACK) && (state_q == ST_RUN) && id_bad;
            wake_d   = (state_q == ST_SLEEP) && (state_d == ST_ACK);
            clk_en_d = (state_d != ST_SLEEP);

            for (int b = 0; b < NB_BARR; b++) begin
                clr_vec[b] = (state_q == ST_ACK) && !err_q && (32'(id_q) == b);
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                state_q  <= ST_RUN;
                id_q     <= '0;
                gnt_q    <= 1'b0;
                err_q    <= 1'b0;
                wake_q   <= 1'b0;
                clk_en_q <= 1'b1;
            end else begin
                state_q  <= state_d;
                id_q     <= id_d;
                gnt_q    <= gnt_d;
                err_q    <= err_d;
                wake_q   <= wake_d;
                clk_en_q <= clk_en_d;
            end
        end

        assign pend_clr[gi*NB_BARR +: NB_BARR] = clr_vec;
        assign core_wait_gnt_o[gi] = gnt_q;
        assign core_wait_err_o[gi] = err_q;
        assign core_wake_o[gi]     = wake_q;
        assign core_clock_en_o[gi] = clk_en_q;
    end

endmodule

// File: tb/tb_barrier_wait_ctrl.sv
// Directed bench for barrier_wait_ctrl: expected grants go into a queue that a
// negedge monitor drains; clock-enable and pending bits are checked inline.
module tb_barrier_wait_ctrl;

    localparam int NB_CORES = 4;
    localparam int NB_BARR  = 2;
    localparam int ID_W     = 2;

    logic                        clk_i = 1'b0;
    logic                        rst_i = 1'b1;
    logic [NB_BARR*NB_CORES-1:0] events = '0;
    logic [NB_CORES-1:0]         req = '0;
    logic [NB_CORES*ID_W-1:0]    wait_id = '0;
    logic [NB_CORES-1:0]         busy = '0;
    logic [NB_CORES-1:0]         gnt, err, clk_en, wake;
    logic [NB_CORES*NB_BARR-1:0] pending;

    barrier_wait_ctrl #(.NB_CORES(NB_CORES), .NB_BARR(NB_BARR), .ID_W(ID_W)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .barrier_events_i(events),
        .core_wait_req_i (req),
        .core_wait_id_i  (wait_id),
        .core_busy_i     (busy),
        .core_wait_gnt_o (gnt),
        .core_wait_err_o (err),
        .core_clock_en_o (clk_en),
        .core_wake_o     (wake),
        .pending_o       (pending)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int   core;
        logic err;
        logic wake;
        int   cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic expect_gnt(input int core, input logic e, input logic w);
        exp_t x;
        x.core = core;
        x.err  = e;
        x.wake = w;
        x.cyc  = cyc + 1;
        exp_q.push_back(x);
    endtask

    task automatic set_id(input int core, input int v);
        wait_id[core*ID_W +: ID_W] = ID_W'(v);
    endtask

    // Monitor: every grant must match the head of the expectation queue.
    initial begin
        exp_t x;
        while (!done) begin
            @(negedge clk_i);
            for (int c = 0; c < NB_CORES; c++) begin
                if (gnt[c]) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_gnt", 32'(c), 32'hFFFF_FFFF);
                    end else begin
                        x = exp_q.pop_front();
                        check("gnt_core", 32'(c), 32'(x.core));
                        check("gnt_err",  32'(err[c]), 32'(x.err));
                        check("gnt_wake", 32'(wake[c]), 32'(x.wake));
                        check("gnt_cycle", 32'(cyc), 32'(x.cyc));
                        $display("grant core=%0d err=%0b wake=%0b cycle=%0d", c, err[c], wake[c], cyc);
                    end
                end else if (wake[c] || err[c]) begin
                    check("wake_err_without_gnt", {wake[c], err[c]}, 32'h0);
                end
            end
        end
    end

    initial begin
        tick(3);
        check("reset_gnt",     32'(gnt), 32'h0);
        check("reset_clk_en",  32'(clk_en), 32'hF);
        check("reset_pending", 32'(pending), 32'h0);
        rst_i = 1'b0;
        tick();

        // 1: pending hit, clock never gated
        events = 8'h02;
        tick();
        events = 8'h00;
        check("t1_pending_set", 32'(pending), 32'h04);
        tick();
        req[1] = 1'b1; set_id(1, 0);
        expect_gnt(1, 1'b0, 1'b0);
        tick();
        req[1] = 1'b0;
        check("t1_clk_en", 32'(clk_en), 32'hF);
        tick();
        check("t1_pending_clr", 32'(pending), 32'h0);

        // 2: sleep, then wake on event
        req[0] = 1'b1; set_id(0, 1);
        tick();
        check("t2_drain_clk_en", 32'(clk_en), 32'hF);
        tick();
        check("t2_sleep_clk_en", 32'(clk_en), 32'hE);
        tick(4);
        check("t2_still_asleep", 32'(clk_en), 32'hE);
        events = 8'h10;
        expect_gnt(0, 1'b0, 1'b1);
        tick();
        events = 8'h00;
        req[0] = 1'b0;
        check("t2_wake_clk_en", 32'(clk_en), 32'hF);
        tick();
        check("t2_pending_clr", 32'(pending), 32'h0);

        // 3: busy core stays in DRAIN, then sleeps; abort from SLEEP
        req[2] = 1'b1; set_id(2, 0); busy[2] = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            check("t3_busy_clk_en", 32'(clk_en), 32'hF);
        end
        tick();
        busy[2] = 1'b0;
        check("t3_busy_last", 32'(clk_en), 32'hF);
        tick();
        check("t3_sleep_clk_en", 32'(clk_en), 32'hB);
        req[2] = 1'b0;
        tick();
        check("t3_abort_clk_en", 32'(clk_en), 32'hF);
        check("t3_abort_pending", 32'(pending), 32'h0);
        tick(2);

        // 4: event coinciding with ACK keeps the bit set
        req[3] = 1'b1; set_id(3, 0); events = 8'h08;
        expect_gnt(3, 1'b0, 1'b0);
        tick();
        req[3] = 1'b0;
        tick();
        events = 8'h00;
        check("t4_set_wins", 32'(pending), 32'h40);
        req[3] = 1'b1;
        expect_gnt(3, 1'b0, 1'b0);
        tick();
        req[3] = 1'b0;
        tick();
        check("t4_pending_clr", 32'(pending), 32'h0);

        // 5: bad id gives err grant and leaves pending alone
        events = 8'h40;
        tick();
        events = 8'h00;
        check("t5_pending_pre", 32'(pending), 32'h20);
        req[0] = 1'b1; set_id(0, 3);
        expect_gnt(0, 1'b1, 1'b0);
        tick();
        req[0] = 1'b0;
        tick();
        check("t5_pending_post", 32'(pending), 32'h20);

        // 6: async reset while sleeping
        req[1] = 1'b1; set_id(1, 1);
        tick(2);
        check("t6_sleep_clk_en", 32'(clk_en), 32'hD);
        #2;
        rst_i = 1'b1;
        #1;
        check("t6_async_clk_en", 32'(clk_en), 32'hF);
        check("t6_async_pending", 32'(pending), 32'h0);
        req[1] = 1'b0;
        tick(2);
        rst_i = 1'b0;
        tick();
        req[1] = 1'b1; set_id(1, 1);
        tick();
        check("t6_drain_clk_en", 32'(clk_en), 32'hF);
        tick();
        check("t6_resleep_clk_en", 32'(clk_en), 32'hD);
        events = 8'h20;
        expect_gnt(1, 1'b0, 1'b1);
        tick();
        events = 8'h00;
        req[1] = 1'b0;
        check("t6_wake_clk_en", 32'(clk_en), 32'hF);
        tick(3);

        check("leftover_expected", 32'(exp_q.size()), 32'h0);
        done = 1'b1;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
